// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the uart_v2 receive path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Sample ticks per bit and the tick (counted from start detect) at which
    // each bit is sampled, roughly mid-bit.
    localparam int UART_OVERSAMPLE = 4;
    localparam int UART_SAMPLE_PH  = 2;
    localparam int UART_PH_W       = $clog2(UART_OVERSAMPLE);

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running divider producing a one-clk sample tick
module uart_baud_tick #(
    parameter int DIVISOR = 27
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIVISOR-1 and wrap; never stops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/uart_v2_rx.sv
// rtl/uart_v2_rx.sv - 8N1 receiver with holding register and sticky error flags
module uart_v2_rx
    import uart_pkg::*;
#(
    parameter int DIVISOR   = 27,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clear,
    output logic                 rx_busy
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [UART_PH_W-1:0] SAMPLE_PH = UART_PH_W'(UART_SAMPLE_PH);

    logic                 tick;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 armed;
    rx_state_t            state;
    rx_state_t            state_next;
    logic [UART_PH_W-1:0] ph;
    logic [UART_PH_W-1:0] ph_next;
    logic [UART_PH_W-1:0] ph_inc;
    logic                 sample;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic                 deliver_set;
    logic                 ferr_set;
    logic                 deliver_q;

    uart_baud_tick #(
        .DIVISOR (DIVISOR)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_line;
            rx_s    <= rx_meta;
        end
    end

    // Arm only after seeing an idle-high line, so a reset released mid-frame
    // cannot mistake a low data bit for a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b0;
        end else if (tick && rx_s) begin
            armed <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, phase/bit counters and shifter; ph counts ticks since start
    // detect and a bit is sampled on the tick that brings it to SAMPLE_PH.
    always_comb begin
        state_next  = state;
        ph_next     = ph;
        bit_next    = bit_cnt;
        shift_next  = shift;
        deliver_set = 1'b0;
        ferr_set    = 1'b0;
        ph_inc      = ph + UART_PH_W'(1);
        sample      = (ph_inc == SAMPLE_PH);
        if (tick) begin
            case (state)
                IDLE: begin
                    if (armed && !rx_s) begin
                        state_next = START;
                        ph_next    = '0;
                    end
                end
                START: begin
                    ph_next = ph_inc;
                    if (sample) begin
                        if (rx_s) begin
                            state_next = IDLE;
                        end else begin
                            state_next = DATA;
                            bit_next   = '0;
                        end
                    end
                end
                DATA: begin
                    ph_next = ph_inc;
                    if (sample) begin
                        shift_next = {rx_s, shift[DATA_BITS-1:1]};
                        bit_next   = bit_cnt + BW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state_next = STOP;
                        end
                    end
                end
                STOP: begin
                    ph_next = ph_inc;
                    if (sample) begin
                        if (rx_s) begin
                            deliver_set = 1'b1;
                            state_next  = IDLE;
                        end else begin
                            ferr_set   = 1'b1;
                            state_next = WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Datapath registers driven by the FSM decisions above.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph        <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            deliver_q <= 1'b0;
        end else begin
            ph        <= ph_next;
            bit_cnt   <= bit_next;
            shift     <= shift_next;
            deliver_q <= deliver_set;
        end
    end

    // Holding register: load on delivery unless still full and not being
    // acked this clk; a lone ack empties it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (deliver_q) begin
            if (!rx_valid || rx_ack) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set in the same clk as err_clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (err_clear) begin
                frame_err <= 1'b0;
            end
            if (deliver_q && rx_valid && !rx_ack) begin
                overrun <= 1'b1;
            end else if (err_clear) begin
                overrun <= 1'b0;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_v2_rx.sv
// tb/tb_uart_v2_rx.sv - self-checking bench for uart_v2_rx
module tb_uart_v2_rx;

    localparam int BIT = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       man_ack;
    logic       auto_pulse;
    logic       auto_ack;
    logic       frame_err;
    logic       overrun;
    logic       err_clear;
    logic       rx_busy;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int rise_count = 0;
    int busy_cnt = 0;
    logic prev_valid = 1'b0;
    logic [7:0] got[$];

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t tbl[6];

    assign rx_ack = man_ack | auto_pulse;

    uart_v2_rx #(
        .DIVISOR   (4),
        .DATA_BITS (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_line   (rx_line),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clear (err_clear),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            rise_count <= rise_count + 1;
            rise_cyc   <= cyc;
        end
        prev_valid <= rx_valid;
        if (rx_busy) busy_cnt <= busy_cnt + 1;
    end

    initial begin
        auto_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_ack && rx_valid) begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
                got.push_back(rx_data);
                auto_pulse = 1'b1;
                @(negedge clk);
                auto_pulse = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int nbits);
        repeat (nbits * BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        start_cyc = cyc;
        rx_line = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx_line = stop_bit;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic pulse_ack();
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int rc0;
        int bc0;
        int diff;
        int waited;
        logic       m_valid;
        logic [7:0] m_data;
        logic       m_ferr;
        logic       m_ovr;
        logic [7:0] d;
        logic       stop;

        tbl[0] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0};
        tbl[1] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};
        tbl[2] = '{8'hF0, 1'b0, 1'b0, 8'h01, 1'b1};
        tbl[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
        tbl[4] = '{8'hFE, 1'b0, 1'b0, 8'h80, 1'b1};
        tbl[5] = '{8'h7F, 1'b1, 1'b1, 8'h7F, 1'b0};

        rx_line   = 1'b1;
        man_ack   = 1'b0;
        err_clear = 1'b0;
        auto_ack  = 1'b0;
        #1 reset_n = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_rx_busy", rx_busy, 0);
        idle(2);

        send_frame(8'hA5, 1'b1);
        chk("a5_valid", rx_valid, 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_frame_err", frame_err, 0);
        diff = rise_cyc - start_cyc;
        chk("a5_rise_latency_in_window", (diff >= 155 && diff <= 160), 1);
        pulse_ack();
        chk("a5_ack_clears_valid", rx_valid, 0);

        got.delete();
        auto_ack = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        waited = 0;
        while (got.size() < 2 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        auto_ack = 1'b0;
        chk("b2b_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("b2b_first", got[0], 8'h00);
            chk("b2b_second", got[1], 8'hFF);
        end
        chk("b2b_overrun", overrun, 0);
        chk("b2b_valid_drained", rx_valid, 0);

        send_frame(8'h3C, 1'b1);
        idle(1);
        send_frame(8'hC3, 1'b1);
        chk("ovr_flag", overrun, 1);
        chk("ovr_data_kept", rx_data, 8'h3C);
        chk("ovr_valid", rx_valid, 1);
        pulse_clear();
        chk("ovr_cleared", overrun, 0);
        pulse_ack();
        chk("ovr_ack_clears_valid", rx_valid, 0);

        rc0 = rise_count;
        send_frame(8'h55, 1'b0);
        idle(40);
        chk("ferr_flag", frame_err, 1);
        chk("ferr_valid_unchanged", rx_valid, 0);
        chk("ferr_no_delivery_during_break", rise_count - rc0, 0);
        chk("ferr_busy_in_break", rx_busy, 1);
        rx_line = 1'b1;
        idle(2);
        send_frame(8'h12, 1'b1);
        chk("after_break_valid", rx_valid, 1);
        chk("after_break_data", rx_data, 8'h12);
        chk("ferr_sticky", frame_err, 1);
        pulse_clear();
        pulse_ack();
        chk("ferr_cleared", frame_err, 0);

        bc0 = busy_cnt;
        rc0 = rise_count;
        rx_line = 1'b0;
        repeat (6) @(negedge clk);
        rx_line = 1'b1;
        idle(3);
        chk("glitch_busy_pulsed", (busy_cnt > bc0), 1);
        chk("glitch_busy_back_low", rx_busy, 0);
        chk("glitch_no_byte", rise_count - rc0, 0);
        chk("glitch_frame_err", frame_err, 0);
        chk("glitch_overrun", overrun, 0);

        rx_line = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        rc0 = rise_count;
        repeat (6 * BIT) @(negedge clk);
        rx_line = 1'b1;
        idle(2);
        chk("midreset_no_byte", rise_count - rc0, 0);
        chk("midreset_valid", rx_valid, 0);
        chk("midreset_frame_err", frame_err, 0);
        chk("midreset_idle", rx_busy, 0);
        send_frame(8'h81, 1'b1);
        chk("midreset_next_valid", rx_valid, 1);
        chk("midreset_next_data", rx_data, 8'h81);
        pulse_ack();
        idle(1);

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].d, tbl[i].stop);
            if (!tbl[i].stop) begin
                rx_line = 1'b1;
                idle(2);
            end else begin
                idle(1);
            end
            chk($sformatf("tbl%0d_valid", i), rx_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_data", i), rx_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_frame_err", i), frame_err, tbl[i].exp_ferr);
            chk($sformatf("tbl%0d_overrun", i), overrun, 0);
            pulse_ack();
            pulse_clear();
        end

        m_valid = 1'b0;
        m_data  = 8'h7F;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        for (int i = 0; i < 24; i++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(d, stop);
            if (stop) begin
                if (!m_valid) begin
                    m_data  = d;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else begin
                m_ferr  = 1'b1;
                rx_line = 1'b1;
            end
            chk($sformatf("rnd%0d_valid", i), rx_valid, m_valid);
            chk($sformatf("rnd%0d_data", i), rx_data, m_data);
            chk($sformatf("rnd%0d_flags", i), {frame_err, overrun}, {m_ferr, m_ovr});
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                m_valid = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_clear();
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
            if (!stop) idle(1);
            idle($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
